m6809_stack_seq: RTL
====================

M6809_STACK_SEQ -- requirements
Module: m6809_stack_seq

Interface
REQ-001 Parameter ADDR_W, default 16, sets the address and stack-pointer width (minimum 16).
REQ-002 Parameter ACK_WAIT, default 1, enables mem_ack wait-state handling when 1; when 0, mem_ack is ignored and treated as 1.
REQ-003 clk  in  1  Single clock; all state updates on the rising edge.
REQ-004 reset_b  in  1  Asynchronous, active-low reset.
REQ-005 start  in  1  One-cycle request; the cycle in which the post-byte register updates.
REQ-006 ir_in  in  8  Opcode: 0x34 PSHS, 0x35 PULS, 0x36 PSHU, 0x37 PULU.
REQ-007 din  in  8  Post-byte register mask, captured directly on the start cycle.
REQ-008 s_in, u_in  in  ADDR_W each  Current S and U pointers.
REQ-009 reg_rdata  in  8  Byte of the register file addressed by reg_sel/reg_hi.
REQ-010 mem_rdata  in  8  Read data; valid in the cycle where mem_ack=1.
REQ-011 mem_ack  in  1  Memory accepts the current access.
REQ-012 busy  out  1  A sequence is active.
REQ-013 done  out  1  One-cycle completion pulse.
REQ-014 mem_req, mem_we  out  1 each  Access request; mem_we=1 for a write.
REQ-015 mem_addr  out  ADDR_W  Access address.
REQ-016 mem_wdata  out  8  Write data, equal to reg_rdata.
REQ-017 reg_sel  out  4  Register code: CC=0, A=1, B=2, DP=3, X=4, Y=5, U=6, S=7, PC=8.
REQ-018 reg_hi  out  1  Selects the high byte of a 16-bit register.
REQ-019 reg_we, reg_wdata  out  1, 8  Register-file byte write; reg_wdata is mem_rdata.
REQ-020 sp_we, sp_sel, sp_out  out  1, 1, ADDR_W  Final pointer writeback; sp_sel=0 selects S, 1 selects U.

Function
REQ-021 States SHALL be IDLE, (DEAD), ACCESS and FINISH; start is accepted only in IDLE with a valid opcode, and is otherwise ignored.
REQ-022 On acceptance, the opcode, post-byte, and working pointer (s_in for PSHS/PULS, u_in for PSHU/PULU) SHALL be latched, and busy=1 SHALL assert from the next cycle.
REQ-023 Post-byte bit order SHALL be b0 CC, b1 A, b2 B, b3 DP, b4 X, b5 Y, b6 the other stack pointer (U for S-ops, S for U-ops), and b7 PC.
REQ-024 Push SHALL walk bits from b7 down to b0; for each byte the pointer is pre-decremented and mem_addr equals the new pointer; 16-bit registers SHALL be stored low byte first, then high byte.
REQ-025 Pull SHALL walk bits from b0 up to b7; mem_addr equals the pointer, which is post-incremented; 16-bit registers SHALL be loaded high byte first, then low byte; reg_we=1 only in the cycle where mem_ack=1.
REQ-026 Each byte SHALL hold mem_req, mem_addr, reg_sel and reg_hi stable until mem_ack=1, then advance on the next edge.
REQ-027 After the last byte the block SHALL enter FINISH for one cycle, with done=1, sp_we=1 and sp_out equal to the final pointer; it then returns to IDLE with busy=0.
REQ-028 Post-byte 0x00 SHALL skip ACCESS and go straight to FINISH, with sp_out equal to the unchanged pointer.
REQ-029 Pointer arithmetic SHALL be modulo 2^ADDR_W; wrap-around through 0 is legal.
REQ-030 start asserted while busy=1 SHALL be ignored.

Reset
REQ-031 reset_b=0 SHALL force IDLE and clear all outputs to 0, aborting any active sequence with no writeback.

Configuration
REQ-032 Macro M6809_CYCLE_ACCURATE_EN defined: the block SHALL insert 3 DEAD cycles (busy=1, mem_req=0) between acceptance and the first access, for all four opcodes, giving the 6809 total of 5+n cycles. Macro undefined: the first access occurs in the cycle after acceptance.

Structure
REQ-033 Opcode constants, register codes and state encoding SHALL reside in the shared package m6809_pkg.
REQ-034 Next-register selection SHALL be a sub-module, m6809_stack_pick: a combinational priority picker taking the remaining mask and direction, and returning the next bit index and a none flag.

Verification
REQ-035 PSHS, din=0xFF, s_in=0x1000, ack always 1 -> 12 writes at 0x0FFF down to 0x0FF4, in the order PCL, PCH, UL, UH, YL, YH, XL, XH, DP, B, A, CC; sp_out=0x0FF4; done 1 cycle after the last write.
REQ-036 PULU, din=0x06, u_in=0x2000 -> reads 0x2000 into A and 0x2001 into B; sp_sel=1; sp_out=0x2002.
REQ-037 PSHS, din=0x00 -> no mem_req; done and sp_we with sp_out=s_in; total busy of 1 cycle (4 with the macro defined).
REQ-038 PSHU, din=0x40, u_in=0x0001 with mem_ack held low for 2 cycles per byte -> writes SL to 0x0000 and SH to 0xFFFF; each address held 3 cycles; sp_out=0xFFFF.
REQ-039 reset_b pulsed low mid-PULS -> busy, mem_req, reg_we and sp_we=0 immediately; no done; a following start is accepted normally.
REQ-040 start pulsed with ir_in=0x1F, and a second start during busy -> neither is accepted, and the active sequence completes unchanged.

Source files
------------

// File: rtl/m6809_pkg.sv
// Shared constants for the 6809 stack push/pull sequencer: opcodes,
// register-file codes, FSM state encoding and small decode helpers.
package m6809_pkg;

  // Stack opcodes
  localparam logic [7:0] OP_PSHS = 8'h34;
  localparam logic [7:0] OP_PULS = 8'h35;
  localparam logic [7:0] OP_PSHU = 8'h36;
  localparam logic [7:0] OP_PULU = 8'h37;

  // Register-file codes driven on reg_sel
  localparam logic [3:0] REG_CC = 4'd0;
  localparam logic [3:0] REG_A  = 4'd1;
  localparam logic [3:0] REG_B  = 4'd2;
  localparam logic [3:0] REG_DP = 4'd3;
  localparam logic [3:0] REG_X  = 4'd4;
  localparam logic [3:0] REG_Y  = 4'd5;
  localparam logic [3:0] REG_U  = 4'd6;
  localparam logic [3:0] REG_S  = 4'd7;
  localparam logic [3:0] REG_PC = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DEAD   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // All four stack opcodes share the upper six bits; bit0 = pull, bit1 = U-op.
  function automatic logic is_stack_op(input logic [7:0] op);
    return op[7:2] == OP_PSHS[7:2];
  endfunction

  // Map a post-byte bit index to a register code. Bit 6 names the
  // stack pointer that is NOT the one being used for the transfer.
  function automatic logic [3:0] reg_code(input logic [2:0] idx, input logic op_u);
    logic [3:0] code;
    case (idx)
      3'd6:    code = op_u ? REG_S : REG_U;
      3'd7:    code = REG_PC;
      default: code = {1'b0, idx};
    endcase
    return code;
  endfunction

endpackage

// File: rtl/m6809_stack_seq_if.sv
// Memory bus between the stack sequencer (master) and memory (slave).
//
// Handshake: mem_req is the valid, mem_ack is the ready. A byte transfers
// on a rising edge where both are 1. While mem_req=1 and mem_ack=0 the
// master holds mem_we, mem_addr and mem_wdata stable. mem_rdata is only
// meaningful in the cycle where mem_ack=1 on a read.
interface m6809_stack_seq_if #(
  parameter int ADDR_W = 16
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/m6809_stack_pick.sv
// Combinational priority picker over the remaining post-byte mask.
// dir_down=1 (push) returns the highest set bit, otherwise the lowest.
module m6809_stack_pick (
  input  logic [7:0] mask,
  input  logic       dir_down,
  output logic [2:0] idx,
  output logic       none
);

  // Later loop iterations override earlier ones, giving the priority order.
  always_comb begin
    idx  = 3'd0;
    none = (mask == 8'h00);
    if (dir_down) begin
      for (int i = 0; i < 8; i++) begin
        if (mask[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (mask[i]) idx = 3'(i);
      end
    end
  end

endmodule

// File: rtl/m6809_stack_seq.sv
// 6809 PSHS/PULS/PSHU/PULU byte sequencer.
// Optional macro M6809_CYCLE_ACCURATE_EN inserts three dead cycles between
// acceptance and the first access, matching the original 5+n cycle count.
module m6809_stack_seq
  import m6809_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int ACK_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              start,
  input  logic [7:0]        ir_in,
  input  logic [7:0]        din,
  input  logic [ADDR_W-1:0] s_in,
  input  logic [ADDR_W-1:0] u_in,
  input  logic [7:0]        reg_rdata,
  m6809_stack_seq_if.master mem,
  output logic              busy,
  output logic              done,
  output logic [3:0]        reg_sel,
  output logic              reg_hi,
  output logic              reg_we,
  output logic [7:0]        reg_wdata,
  output logic              sp_we,
  output logic              sp_sel,
  output logic [ADDR_W-1:0] sp_out,
  output state_t            dbg_state
);

  state_t            state_q, state_d;
  logic              op_push_q;   // 1 = push, 0 = pull
  logic              op_u_q;      // 1 = U stack, 0 = S stack
  logic [7:0]        mask_q;      // registers still to transfer
  logic [ADDR_W-1:0] ptr_q;       // working stack pointer
  logic              second_q;    // second byte of a 16-bit register

  logic [2:0]        pick_idx;
  logic              pick_none;
  logic              accept;
  logic              ack_eff;
  logic              req;
  logic              xfer;
  logic              is16;
  logic              byte_last;
  logic [7:0]        mask_rest;
  logic [ADDR_W-1:0] ptr_dec;
  logic [ADDR_W-1:0] ptr_inc;

`ifdef M6809_CYCLE_ACCURATE_EN
  logic [1:0]        dead_cnt_q;
`endif

  m6809_stack_pick u_pick (
    .mask     (mask_q),
    .dir_down (op_push_q),
    .idx      (pick_idx),
    .none     (pick_none)
  );

  assign accept    = (state_q == ST_IDLE) && start && is_stack_op(ir_in);
  assign ack_eff   = (ACK_WAIT != 0) ? mem.mem_ack : 1'b1;
  assign req       = (state_q == ST_ACCESS) && !pick_none;
  assign xfer      = req && ack_eff;
  assign is16      = pick_idx[2];
  assign byte_last = !is16 || second_q;
  assign mask_rest = mask_q & ~(8'h01 << pick_idx);
  assign ptr_dec   = ptr_q - ADDR_W'(1);
  assign ptr_inc   = ptr_q + ADDR_W'(1);

  // FSM state register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Latch the request on acceptance, then step pointer and mask per transferred byte
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      op_push_q <= 1'b0;
      op_u_q    <= 1'b0;
      mask_q    <= 8'h00;
      ptr_q     <= '0;
      second_q  <= 1'b0;
    end else if (accept) begin
      op_push_q <= ~ir_in[0];
      op_u_q    <= ir_in[1];
      mask_q    <= din;
      ptr_q     <= ir_in[1] ? u_in : s_in;
      second_q  <= 1'b0;
    end else if (xfer) begin
      ptr_q <= op_push_q ? ptr_dec : ptr_inc;
      if (byte_last) begin
        second_q <= 1'b0;
        mask_q   <= mask_rest;
      end else begin
        second_q <= 1'b1;
      end
    end
  end

`ifdef M6809_CYCLE_ACCURATE_EN
  // Count the dead cycles that precede the first access
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)                 dead_cnt_q <= 2'd0;
    else if (accept)              dead_cnt_q <= 2'd0;
    else if (state_q == ST_DEAD)  dead_cnt_q <= dead_cnt_q + 2'd1;
  end
`endif

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef M6809_CYCLE_ACCURATE_EN
          state_d = ST_DEAD;
`else
          state_d = (din == 8'h00) ? ST_FINISH : ST_ACCESS;
`endif
        end
      end
      ST_DEAD: begin
`ifdef M6809_CYCLE_ACCURATE_EN
        if (dead_cnt_q == 2'd2) state_d = (mask_q == 8'h00) ? ST_FINISH : ST_ACCESS;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_ACCESS: begin
        if (pick_none || (xfer && byte_last && (mask_rest == 8'h00))) state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode; everything is zero outside the state that owns it
  always_comb begin
    mem.mem_req   = req;
    mem.mem_we    = req && op_push_q;
    mem.mem_addr  = '0;
    mem.mem_wdata = 8'h00;
    reg_sel       = 4'd0;
    reg_hi        = 1'b0;
    reg_we        = xfer && !op_push_q;
    reg_wdata     = 8'h00;
    busy          = (state_q != ST_IDLE);
    done          = (state_q == ST_FINISH);
    sp_we         = (state_q == ST_FINISH);
    sp_sel        = 1'b0;
    sp_out        = '0;
    dbg_state     = state_q;
    if (req) begin
      mem.mem_addr = op_push_q ? ptr_dec : ptr_q;
      reg_sel      = reg_code(pick_idx, op_u_q);
      // Push stores low then high; pull loads high then low.
      reg_hi       = is16 && (op_push_q ? second_q : !second_q);
      if (op_push_q) mem.mem_wdata = reg_rdata;
    end
    if (reg_we) reg_wdata = mem.mem_rdata;
    if (state_q == ST_FINISH) begin
      sp_sel = op_u_q;
      sp_out = ptr_q;
    end
  end

endmodule
